// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: PHT selection modes and 2-bit counter codes.
package bp_pkg;

  localparam int unsigned MODE_ALWAYS  = 0;
  localparam int unsigned MODE_BIMODAL = 1;
  localparam int unsigned MODE_GSHARE  = 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] PHT_RESET = WNT;

  // Saturating step of a 2-bit counter towards taken or not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken) begin
      if (c != ST) n = c + 2'd1;
    end else begin
      if (c != SNT) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_pattern_table.sv
// Pattern history table of 2-bit counters plus the non-speculative global history register.
// One combinational read port for lookup, one read-modify-write port for branch resolution.
module bp_pattern_table
  import bp_pkg::*;
#(
  parameter int unsigned PHT_BIT = 5,
  parameter int unsigned MODE    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PHT_BIT-1:0] i_lookup_idx,
  output logic               o_pred_taken,
  input  logic               i_upd_en,
  input  logic [PHT_BIT-1:0] i_upd_idx,
  input  logic               i_upd_taken
);

  localparam int unsigned NumEntries = 1 << PHT_BIT;

  logic [1:0]         r_pht [NumEntries];
  logic [PHT_BIT-1:0] r_ghr;
  logic [PHT_BIT-1:0] w_rd_idx;
  logic [PHT_BIT-1:0] w_wr_idx;

  // Lookup and update both hash with the current (pre-edge) history in gshare mode.
  always_comb begin
    w_rd_idx = i_lookup_idx;
    w_wr_idx = i_upd_idx;
    if (MODE == MODE_GSHARE) begin
      w_rd_idx = i_lookup_idx ^ r_ghr;
      w_wr_idx = i_upd_idx ^ r_ghr;
    end
  end

  assign o_pred_taken = r_pht[w_rd_idx][1];

  // Counter training and history shift on each resolved conditional branch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NumEntries; k++) r_pht[k] <= PHT_RESET;
      r_ghr <= '0;
    end else if (i_upd_en) begin
      r_pht[w_wr_idx] <= ctr_next(r_pht[w_wr_idx], i_upd_taken);
      r_ghr           <= {r_ghr[PHT_BIT-2:0], i_upd_taken};
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// IF-stage predictor: direct-mapped BTB with PHT direction, EX-stage resolution and perf counters.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int unsigned ENTRY_BIT = 5,
  parameter int unsigned PHT_BIT   = 5,
  parameter int unsigned MODE      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic [31:0] IF_ID_pc,
  input  logic [31:0] ID_EX_pc,
  input  logic [31:0] EX_pc_plus_imm,
  input  logic [31:0] EX_alu_result,
  input  logic        ID_EX_is_branch,
  input  logic        ID_EX_is_jal,
  input  logic        ID_EX_is_jalr,
  input  logic        EX_alu_bcond,
  input  logic        update_en,
  output logic        is_flush,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned TagW       = 30 - ENTRY_BIT;
  localparam int unsigned NumEntries = 1 << ENTRY_BIT;

  logic                 r_valid  [NumEntries];
  logic [TagW-1:0]      r_tag    [NumEntries];
  logic [31:0]          r_target [NumEntries];
  logic                 r_uncond [NumEntries];
  logic [31:0]          r_branch_count;
  logic [31:0]          r_mispredict_count;

  logic [ENTRY_BIT-1:0] w_lk_idx;
  logic [TagW-1:0]      w_lk_tag;
  logic [ENTRY_BIT-1:0] w_up_idx;
  logic                 w_hit;
  logic                 w_pht_taken;
  logic                 w_ctrl;
  logic                 w_is_jal;
  logic                 w_is_br;
  logic                 w_br_upd;
  logic [31:0]          w_correct_pc;
  logic [31:0]          w_upd_target;
  logic                 w_upd_uncond;
  logic                 w_flush;

  assign w_lk_idx = current_pc[ENTRY_BIT+1:2];
  assign w_lk_tag = current_pc[31:ENTRY_BIT+2];
  assign w_up_idx = ID_EX_pc[ENTRY_BIT+1:2];

  // Lookup: BTB hit qualifies the direction from the mode-selected source.
  always_comb begin
    w_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    pred_taken = w_hit && ((MODE == MODE_ALWAYS) || r_uncond[w_lk_idx] || w_pht_taken);
  end

  // Resolution: jal outranks branch, branch outranks jalr when several flags are set.
  always_comb begin
    w_ctrl   = update_en && (ID_EX_is_branch || ID_EX_is_jal || ID_EX_is_jalr);
    w_is_jal = ID_EX_is_jal;
    w_is_br  = ID_EX_is_branch && !ID_EX_is_jal;
    if (w_is_jal) begin
      w_correct_pc = EX_pc_plus_imm;
    end else if (w_is_br) begin
      w_correct_pc = EX_alu_bcond ? EX_pc_plus_imm : ID_EX_pc + 32'd4;
    end else begin
      w_correct_pc = EX_alu_result;
    end
    // Branch targets are learnt even when not taken so a later taken outcome can hit.
    w_upd_target = (w_is_jal || w_is_br) ? EX_pc_plus_imm : EX_alu_result;
    w_upd_uncond = !w_is_br;
    w_br_upd     = w_ctrl && w_is_br;
    w_flush      = w_ctrl && (IF_ID_pc != w_correct_pc);
  end

  // Next fetch address: redirect beats prediction beats sequential.
  always_comb begin
    is_flush = w_flush;
    if (w_flush) next_pc = w_correct_pc;
    else if (pred_taken) next_pc = r_target[w_lk_idx];
    else next_pc = current_pc + 32'd4;
  end

  bp_pattern_table #(
    .PHT_BIT (PHT_BIT),
    .MODE    (MODE)
  ) u_pht (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_lookup_idx (current_pc[PHT_BIT+1:2]),
    .o_pred_taken (w_pht_taken),
    .i_upd_en     (w_br_upd),
    .i_upd_idx    (ID_EX_pc[PHT_BIT+1:2]),
    .i_upd_taken  (EX_alu_bcond)
  );

  // BTB fill on every resolved control instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NumEntries; k++) begin
        r_valid[k]  <= 1'b0;
        r_tag[k]    <= '0;
        r_target[k] <= '0;
        r_uncond[k] <= 1'b0;
      end
    end else if (w_ctrl) begin
      r_valid[w_up_idx]  <= 1'b1;
      r_tag[w_up_idx]    <= ID_EX_pc[31:ENTRY_BIT+2];
      r_target[w_up_idx] <= w_upd_target;
      r_uncond[w_up_idx] <= w_upd_uncond;
    end
  end

  // Performance counters, free-running with wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_ctrl) begin
      r_branch_count <= r_branch_count + 32'd1;
      if (w_flush) r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: one DUT per MODE driven in parallel, compared every cycle with a model.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc, IF_ID_pc, ID_EX_pc, EX_pc_plus_imm, EX_alu_result;
  logic        ID_EX_is_branch, ID_EX_is_jal, ID_EX_is_jalr, EX_alu_bcond, update_en;

  logic        o_flush [3];
  logic [31:0] o_npc   [3];
  logic        o_pred  [3];
  logic [31:0] o_bcnt  [3];
  logic [31:0] o_mcnt  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.ENTRY_BIT(5), .PHT_BIT(5), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .current_pc(current_pc), .IF_ID_pc(IF_ID_pc), .ID_EX_pc(ID_EX_pc),
    .EX_pc_plus_imm(EX_pc_plus_imm), .EX_alu_result(EX_alu_result),
    .ID_EX_is_branch(ID_EX_is_branch), .ID_EX_is_jal(ID_EX_is_jal), .ID_EX_is_jalr(ID_EX_is_jalr),
    .EX_alu_bcond(EX_alu_bcond), .update_en(update_en), .is_flush(o_flush[0]),
    .next_pc(o_npc[0]), .pred_taken(o_pred[0]), .branch_count(o_bcnt[0]),
    .mispredict_count(o_mcnt[0]));

  branch_predictor_gshare #(.ENTRY_BIT(5), .PHT_BIT(5), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .current_pc(current_pc), .IF_ID_pc(IF_ID_pc), .ID_EX_pc(ID_EX_pc),
    .EX_pc_plus_imm(EX_pc_plus_imm), .EX_alu_result(EX_alu_result),
    .ID_EX_is_branch(ID_EX_is_branch), .ID_EX_is_jal(ID_EX_is_jal), .ID_EX_is_jalr(ID_EX_is_jalr),
    .EX_alu_bcond(EX_alu_bcond), .update_en(update_en), .is_flush(o_flush[1]),
    .next_pc(o_npc[1]), .pred_taken(o_pred[1]), .branch_count(o_bcnt[1]),
    .mispredict_count(o_mcnt[1]));

  branch_predictor_gshare #(.ENTRY_BIT(5), .PHT_BIT(5), .MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .current_pc(current_pc), .IF_ID_pc(IF_ID_pc), .ID_EX_pc(ID_EX_pc),
    .EX_pc_plus_imm(EX_pc_plus_imm), .EX_alu_result(EX_alu_result),
    .ID_EX_is_branch(ID_EX_is_branch), .ID_EX_is_jal(ID_EX_is_jal), .ID_EX_is_jalr(ID_EX_is_jalr),
    .EX_alu_bcond(EX_alu_bcond), .update_en(update_en), .is_flush(o_flush[2]),
    .next_pc(o_npc[2]), .pred_taken(o_pred[2]), .branch_count(o_bcnt[2]),
    .mispredict_count(o_mcnt[2]));

  // ---------------- behavioural model ----------------
  bit          m_valid [32];
  logic [31:0] m_tag   [32];
  logic [31:0] m_tgt   [32];
  bit          m_unc   [32];
  int          m_pht   [3][32];
  int          m_ghr   [3];
  logic [31:0] m_bcnt, m_mcnt;

  function automatic void m_clear();
    for (int e = 0; e < 32; e++) begin
      m_valid[e] = 0; m_tag[e] = 0; m_tgt[e] = 0; m_unc[e] = 0;
      for (int m = 0; m < 3; m++) m_pht[m][e] = 1;
    end
    for (int m = 0; m < 3; m++) m_ghr[m] = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  function automatic int ent(input logic [31:0] pc);
    return int'((pc / 4) % 32);
  endfunction

  function automatic int pidx(input int m, input logic [31:0] pc);
    return (m == 2) ? (ent(pc) ^ m_ghr[m]) : ent(pc);
  endfunction

  function automatic bit m_ctrl();
    return update_en && (ID_EX_is_branch || ID_EX_is_jal || ID_EX_is_jalr);
  endfunction

  function automatic logic [31:0] m_correct();
    if (ID_EX_is_jal) return EX_pc_plus_imm;
    if (ID_EX_is_branch) return EX_alu_bcond ? EX_pc_plus_imm : ID_EX_pc + 32'd4;
    return EX_alu_result;
  endfunction

  function automatic bit m_flush();
    return m_ctrl() && (IF_ID_pc != m_correct());
  endfunction

  function automatic bit m_pred(input int m);
    int e;
    bit hit;
    e   = ent(current_pc);
    hit = m_valid[e] && (m_tag[e] == current_pc / 128);
    return hit && (m == 0 || m_unc[e] || m_pht[m][pidx(m, current_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_npc(input int m);
    if (m_flush()) return m_correct();
    if (m_pred(m)) return m_tgt[ent(current_pc)];
    return current_pc + 32'd4;
  endfunction

  // Model state advance; inputs are stable here because they change 1 time unit after the edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear();
    end else if (m_ctrl()) begin
      int e;
      m_bcnt = m_bcnt + 1;
      if (m_flush()) m_mcnt = m_mcnt + 1;
      e = ent(ID_EX_pc);
      m_valid[e] = 1;
      m_tag[e]   = ID_EX_pc / 128;
      m_tgt[e]   = (ID_EX_is_jal || ID_EX_is_branch) ? EX_pc_plus_imm : EX_alu_result;
      m_unc[e]   = ID_EX_is_jal || ID_EX_is_jalr;
      if (ID_EX_is_branch && !ID_EX_is_jal) begin
        for (int m = 0; m < 3; m++) begin
          int p;
          p = pidx(m, ID_EX_pc);
          if (EX_alu_bcond) m_pht[m][p] = (m_pht[m][p] == 3) ? 3 : m_pht[m][p] + 1;
          else m_pht[m][p] = (m_pht[m][p] == 0) ? 0 : m_pht[m][p] - 1;
          m_ghr[m] = ((m_ghr[m] * 2) + (EX_alu_bcond ? 1 : 0)) % 32;
        end
      end
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      chk1($sformatf("dut%0d is_flush", m), o_flush[m], m_flush());
      chk32($sformatf("dut%0d next_pc", m), o_npc[m], m_npc(m));
      chk1($sformatf("dut%0d pred_taken", m), o_pred[m], m_pred(m));
      chk32($sformatf("dut%0d branch_count", m), o_bcnt[m], m_bcnt);
      chk32($sformatf("dut%0d mispredict_count", m), o_mcnt[m], m_mcnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input logic [31:0] pc);
    update_en = 0; ID_EX_is_branch = 0; ID_EX_is_jal = 0; ID_EX_is_jalr = 0;
    EX_alu_bcond = 0; current_pc = pc; IF_ID_pc = pc + 32'd4;
  endtask

  // kind: 0 branch, 1 jal, 2 jalr
  task automatic resolve(input int kind, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic [31:0] ifid, input logic [31:0] cur);
    update_en = 1; ID_EX_is_branch = (kind == 0); ID_EX_is_jal = (kind == 1);
    ID_EX_is_jalr = (kind == 2); EX_alu_bcond = taken; ID_EX_pc = pc;
    EX_pc_plus_imm = tgt; EX_alu_result = tgt; IF_ID_pc = ifid; current_pc = cur;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_clear();
    reset = 1;
    ID_EX_pc = 0; EX_pc_plus_imm = 0; EX_alu_result = 0;
    idle(32'h0);
    // 1: reset state
    cyc(); idle(32'h0); #1;
    for (int m = 0; m < 3; m++) begin
      chk32("lit reset next_pc 0x4", o_npc[m], 32'h4);
      chk1("lit reset pred", o_pred[m], 1'b0);
      chk32("lit reset bcnt", o_bcnt[m], 32'h0);
      chk32("lit reset mcnt", o_mcnt[m], 32'h0);
    end
    cyc(); idle(32'h40); #1;
    chk32("lit reset next_pc 0x44", o_npc[2], 32'h44);
    // 2: jal mispredict then BTB hit
    cyc(); reset = 0; resolve(1, 32'h10, 32'h100, 1'b0, 32'h14, 32'h14); #1;
    chk1("lit jal flush", o_flush[0], 1'b1);
    chk32("lit jal redirect", o_npc[2], 32'h100);
    cyc(); idle(32'h10); #1;
    for (int m = 0; m < 3; m++) begin
      chk32("lit jal btb next_pc", o_npc[m], 32'h100);
      chk1("lit jal btb pred", o_pred[m], 1'b1);
      chk32("lit jal mcnt", o_mcnt[m], 32'h1);
    end
    // 3: bimodal training and saturation at 00
    cyc(); resolve(0, 32'h20, 32'h80, 1'b1, 32'h24, 32'h24); #1;
    chk1("lit beq flush", o_flush[1], 1'b1);
    chk32("lit beq redirect", o_npc[1], 32'h80);
    cyc(); idle(32'h20); #1;
    chk1("lit bimodal WT pred", o_pred[1], 1'b1);
    chk32("lit bimodal WT next_pc", o_npc[1], 32'h80);
    cyc(); resolve(0, 32'h20, 32'h80, 1'b0, 32'h24, 32'h30); #1;
    chk1("lit beq nt no flush", o_flush[1], 1'b0);
    cyc(); resolve(0, 32'h20, 32'h80, 1'b0, 32'h24, 32'h30);
    cyc(); idle(32'h20); #1;
    chk1("lit bimodal SNT pred", o_pred[1], 1'b0);
    chk32("lit bimodal SNT next_pc", o_npc[1], 32'h24);
    cyc(); resolve(0, 32'h20, 32'h80, 1'b0, 32'h24, 32'h30);
    cyc(); resolve(0, 32'h20, 32'h80, 1'b1, 32'h80, 32'h30);
    cyc(); idle(32'h20); #1;
    chk1("lit bimodal saturate low", o_pred[1], 1'b0);
    chk32("lit always-taken hit", o_npc[0], 32'h80);
    // 4: gshare hashing with history
    cyc(); reset = 1;
    cyc(); reset = 0; resolve(0, 32'h28, 32'h200, 1'b0, 32'h2C, 32'h0);
    cyc(); resolve(0, 32'h40, 32'h400, 1'b1, 32'h400, 32'h0);
    cyc(); resolve(0, 32'h20, 32'h80, 1'b1, 32'h80, 32'h0);
    cyc(); idle(32'h28); #1;
    chk1("lit gshare pht[9] pred", o_pred[2], 1'b1);
    chk32("lit gshare next_pc", o_npc[2], 32'h200);
    chk1("lit bimodal pht[10] pred", o_pred[1], 1'b0);
    chk32("lit bimodal next_pc", o_npc[1], 32'h2C);
    // 5: tag alias and same-cycle update/lookup
    cyc(); idle(32'hA0); #1;
    chk1("lit alias miss pred", o_pred[0], 1'b0);
    chk32("lit alias miss next_pc", o_npc[0], 32'hA4);
    cyc(); resolve(1, 32'h20, 32'h300, 1'b0, 32'h300, 32'h20); #1;
    chk1("lit same-cycle no flush", o_flush[0], 1'b0);
    chk32("lit same-cycle old target", o_npc[0], 32'h80);
    cyc(); idle(32'h20); #1;
    chk32("lit new target", o_npc[0], 32'h300);
    // 6: async reset between edges; update_en=0 never flushes
    cyc(); idle(32'h20); ID_EX_is_jal = 1; IF_ID_pc = 32'h999; #1;
    chk1("lit no update_en no flush", o_flush[0], 1'b0);
    #1 reset = 1;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk1("lit async reset pred", o_pred[m], 1'b0);
      chk32("lit async reset next_pc", o_npc[m], 32'h24);
      chk32("lit async reset bcnt", o_bcnt[m], 32'h0);
    end
    cyc(); reset = 0;
    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      int kind;
      cyc();
      reset = ($urandom_range(0, 149) == 0);
      idle(32'($urandom_range(0, 127)) << 2);
      kind = int'($urandom_range(0, 3));
      ID_EX_pc = ($urandom_range(0, 3) == 0) ? current_pc : 32'($urandom_range(0, 127)) << 2;
      EX_pc_plus_imm = 32'($urandom_range(0, 127)) << 2;
      EX_alu_result  = 32'($urandom_range(0, 127)) << 2;
      EX_alu_bcond   = 1'($urandom_range(0, 1));
      update_en      = ($urandom_range(0, 3) != 0);
      ID_EX_is_branch = (kind == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
      ID_EX_is_jal    = (kind == 1);
      ID_EX_is_jalr   = (kind == 2);
      IF_ID_pc = ($urandom_range(0, 1) == 1) ? m_correct() : 32'($urandom_range(0, 127)) << 2;
    end
    cyc();
    reset = 0;
    idle(32'h0);
    cyc();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
